rtc_bus_arbiter: RTL and testbench
==================================

Name: rtc_bus_arbiter

Overview:
Arbitrates the shared RTC multiplexed address/data bus among four requesters: init/reset sequencer, user time write, chrono programming, and periodic read polling. Latches one requester's transaction only at a bus boundary and issues it to the RTC protocol engine. It then waits for completion and returns ack plus read data. Fixed priority with burst lock and a completion watchdog replace the ad-hoc flag-based address/data muxing around the protocol engine.

Parameters:
TIMEOUT, 255, cycles allowed in WAIT before a transaction is aborted (>=2)
MAX_BURST, 8, max consecutive locked transactions granted to one owner before the lock is forcibly released

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
req  in  4  per-requester request; index 0 init (highest), 1 write, 2 chrono, 3 read poll (lowest)
lock  in  4  per-requester request to keep the bus for the next transaction
wr_in  in  4  per-requester 1=write, 0=read
addr_in  in  32  packed 4x8 RTC register addresses; requester i at [8i+7:8i]
wdata_in  in  32  packed 4x8 write data
txn_start  out  1  one-cycle pulse to protocol engine
txn_write  out  1  transaction direction
txn_addr  out  8  RTC register address
txn_wdata  out  8  write data
txn_done  in  1  engine completion pulse
txn_rdata  in  8  engine read data, valid with txn_done
grant  out  4  one-hot current owner, 0 when idle
ack  out  4  one-cycle completion pulse to owner
rdata_out  out  8  captured read data, valid with ack
err  out  1  one-cycle pulse with ack on watchdog timeout
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs registered. On reset every output is 0, state=IDLE, lock owner invalid, burst count 0. Reset mid-transaction aborts immediately: no ack, no err.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req bit is set, choose a winner.
  - Winner is the lock owner if the owner is valid and req[owner]=1; otherwise the lowest-index asserted req.
  - Register addr/wdata/wr of the winner into txn_*, set grant one-hot, go to ISSUE.
  - If the owner is valid and req[owner]=0, invalidate the lock and apply fixed priority in the same cycle.
- ISSUE: txn_start=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: increment the counter each cycle.
  - txn_done=1: capture txn_rdata into rdata_out (reads only; writes leave it unchanged). Go to DONE.
  - Counter reaches TIMEOUT-1 without txn_done: flag timeout, go to DONE.
  - txn_done in the same cycle as the limit: completion wins, no error.
- DONE: ack[owner]=1 and err=timeout flag for this single cycle. grant is held through DONE and cleared on return to IDLE.
  - Lock update: owner valid only if lock[owner]=1, no timeout, and burst count < MAX_BURST-1. Burst count increments on a kept lock and resets to 0 otherwise.
  - Go to IDLE.
- Timing: req seen in IDLE at cycle T gives txn_start at T+1. txn_done at cycle D gives ack at D+1 and IDLE at D+2. IDLE lasts at least one cycle between transactions.
- Request stability: requesters hold req/addr/wdata/wr until ack. Inputs are sampled only in IDLE. Changes after grant are ignored.
- Deasserted request: a requester that drops req mid-transaction still completes and still receives ack.
- txn_done outside WAIT is ignored.
- Timeout on a locked burst releases the lock.

Test Plan:
- Single read: req=4'b1000, wr_in[3]=0, addr=8'h21; engine returns txn_rdata=8'h45 on txn_done 10 cycles after txn_start -> txn_start 1 cycle after req, txn_addr=8'h21, ack=4'b1000 and rdata_out=8'h45 one cycle after done, grant 0 afterwards.
- Priority: req=4'b1110 simultaneously -> grant=4'b0010 first. After its ack, with req=4'b1100, grant=4'b0100, then 4'b1000.
- Burst lock with starvation limit: requester 1 holds req and lock with MAX_BURST=8 while req[3]=1 -> 8 consecutive grants to 1, then the lock is released; after requester 1's 9th fixed-priority grant (no lock), requester 3 is granted once requester 1 drops req.
- Watchdog: TIMEOUT=16, engine never pulses txn_done -> ack and err pulse together 16 cycles after txn_start, lock cleared, rdata_out unchanged.
- Done on the limit cycle: txn_done at counter=TIMEOUT-1 -> ack with err=0, read data captured.
- Reset in WAIT: assert reset for 1 cycle -> all outputs 0 next cycle, no ack. A pending req=4'b0001 is re-arbitrated and issued afterwards.

Source files
------------

// File: rtl/rtc_bus_arbiter.sv
// Arbiter for the shared RTC multiplexed address/data bus.
// Four requesters (0 = init sequencer, highest priority; 3 = read poll, lowest)
// compete for the RTC protocol engine. A winner is latched only in IDLE, its
// transaction is issued with a one-cycle start pulse, and completion (or a
// watchdog timeout) is returned as a one-cycle ack to that owner.
// An owner may keep the bus across back-to-back transactions with its lock
// bit, up to MAX_BURST consecutive grants.
module rtc_bus_arbiter #(
  parameter int TIMEOUT   = 255,  // cycles allowed in WAIT before abort (>= 2)
  parameter int MAX_BURST = 8     // max consecutive locked grants to one owner
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  lock,
  input  logic [3:0]  wr_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        txn_start,
  output logic        txn_write,
  output logic [7:0]  txn_addr,
  output logic [7:0]  txn_wdata,
  input  logic        txn_done,
  input  logic [7:0]  txn_rdata,
  output logic [3:0]  grant,
  output logic [3:0]  ack,
  output logic [7:0]  rdata_out,
  output logic        err,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [BW-1:0]   burst_reg, burst_next;
  logic [1:0]      owner_reg, owner_next;
  logic            owner_valid_reg, owner_valid_next;
  logic [1:0]      sel_reg, sel_next;
  logic            timeout_reg, timeout_next;

  logic            txn_start_next, txn_write_next, err_next, busy_next;
  logic [7:0]      txn_addr_next, txn_wdata_next, rdata_next;
  logic [3:0]      grant_next, ack_next;

  logic [1:0]      prio_idx, win_idx;
  logic            owner_hit;

  // Winner selection: a valid, still-requesting lock owner beats fixed priority.
  always_comb begin
    prio_idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) prio_idx = 2'(i);
    end
    owner_hit = owner_valid_reg && req[owner_reg];
    win_idx   = owner_hit ? owner_reg : prio_idx;
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    burst_next       = burst_reg;
    owner_next       = owner_reg;
    owner_valid_next = owner_valid_reg;
    sel_next         = sel_reg;
    timeout_next     = timeout_reg;
    txn_start_next   = 1'b0;
    txn_write_next   = txn_write;
    txn_addr_next    = txn_addr;
    txn_wdata_next   = txn_wdata;
    grant_next       = grant;
    ack_next         = 4'b0000;
    rdata_next       = rdata_out;
    err_next         = 1'b0;

    case (state_reg)
      IDLE: begin
        // An owner that stopped requesting gives up its lock right away.
        if (owner_valid_reg && !req[owner_reg]) begin
          owner_valid_next = 1'b0;
          burst_next       = '0;
        end
        if (|req) begin
          sel_next       = win_idx;
          txn_addr_next  = addr_in[{win_idx, 3'b000} +: 8];
          txn_wdata_next = wdata_in[{win_idx, 3'b000} +: 8];
          txn_write_next = wr_in[win_idx];
          grant_next     = 4'b0001 << win_idx;
          txn_start_next = 1'b1;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        count_next   = '0;
        timeout_next = 1'b0;
        state_next   = WAIT;
      end
      WAIT: begin
        count_next = count_reg + 1'b1;
        // Completion takes precedence over a timeout in the same cycle.
        if (txn_done) begin
          if (!txn_write) rdata_next = txn_rdata;
          ack_next   = grant;
          state_next = DONE;
        end else if (count_reg == CW'(TIMEOUT - 2)) begin
          timeout_next = 1'b1;
          ack_next     = grant;
          err_next     = 1'b1;
          state_next   = DONE;
        end
      end
      DONE: begin
        if (lock[sel_reg] && !timeout_reg && (burst_reg < BW'(MAX_BURST - 1))) begin
          owner_valid_next = 1'b1;
          owner_next       = sel_reg;
          burst_next       = burst_reg + 1'b1;
        end else begin
          owner_valid_next = 1'b0;
          burst_next       = '0;
        end
        grant_next = 4'b0000;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and registered outputs; reset aborts any transaction silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      burst_reg       <= '0;
      owner_reg       <= 2'd0;
      owner_valid_reg <= 1'b0;
      sel_reg         <= 2'd0;
      timeout_reg     <= 1'b0;
      txn_start       <= 1'b0;
      txn_write       <= 1'b0;
      txn_addr        <= 8'h00;
      txn_wdata       <= 8'h00;
      grant           <= 4'b0000;
      ack             <= 4'b0000;
      rdata_out       <= 8'h00;
      err             <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      burst_reg       <= burst_next;
      owner_reg       <= owner_next;
      owner_valid_reg <= owner_valid_next;
      sel_reg         <= sel_next;
      timeout_reg     <= timeout_next;
      txn_start       <= txn_start_next;
      txn_write       <= txn_write_next;
      txn_addr        <= txn_addr_next;
      txn_wdata       <= txn_wdata_next;
      grant           <= grant_next;
      ack             <= ack_next;
      rdata_out       <= rdata_next;
      err             <= err_next;
      busy            <= busy_next;
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed testbench for rtc_bus_arbiter with TIMEOUT=16, MAX_BURST=8.
module tb_rtc_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, lock, wr_in;
  logic [31:0] addr_in, wdata_in;
  logic        txn_start, txn_write;
  logic [7:0]  txn_addr, txn_wdata;
  logic        txn_done;
  logic [7:0]  txn_rdata;
  logic [3:0]  grant, ack;
  logic [7:0]  rdata_out;
  logic        err, busy;

  int errors = 0;
  int checks = 0;

  rtc_bus_arbiter #(.TIMEOUT(16), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wr_in(wr_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .txn_start(txn_start),
    .txn_write(txn_write), .txn_addr(txn_addr), .txn_wdata(txn_wdata),
    .txn_done(txn_done), .txn_rdata(txn_rdata), .grant(grant), .ack(ack),
    .rdata_out(rdata_out), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for the start pulse, check the issued transaction, answer after
  // 'delay' cycles with txn_done and check the ack. Returns in the ack cycle.
  task automatic do_txn(input string tag, input logic [3:0] g, input logic [7:0] a,
                        input logic w, input logic [7:0] wd, input int delay,
                        input logic [7:0] rd, input logic [7:0] exp_rd, output int lat);
    int n;
    n = 0;
    tick();
    while (!txn_start && n < 8) begin
      tick();
      n++;
    end
    lat = n + 1;
    if (!txn_start) begin
      check({tag, "_start"}, 32'(txn_start), 32'd1);
      return;
    end
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_addr"}, 32'(txn_addr), 32'(a));
    check({tag, "_wr"}, 32'(txn_write), 32'(w));
    if (w) check({tag, "_wdata"}, 32'(txn_wdata), 32'(wd));
    for (int i = 1; i <= delay; i++) begin
      tick();
      if (i == 1) check({tag, "_start_pulse"}, 32'(txn_start), 32'd0);
    end
    txn_done  = 1'b1;
    txn_rdata = rd;
    check({tag, "_noack"}, 32'(ack), 32'd0);
    tick();
    txn_done  = 1'b0;
    txn_rdata = 8'h00;
    check({tag, "_ack"}, 32'(ack), 32'(g));
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_rdata"}, 32'(rdata_out), 32'(exp_rd));
    $display("txn %s: grant=%b addr=%h wr=%b rdata=%h lat=%0d", tag, grant, txn_addr, txn_write, rdata_out, lat);
  endtask

  initial begin
    int lat, m;
    reset = 1'b1; req = 4'b0; lock = 4'b0; wr_in = 4'b0;
    addr_in = 32'h0; wdata_in = 32'h0; txn_done = 1'b0; txn_rdata = 8'h00;
    tick(); tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(txn_start), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", 32'(rdata_out), 32'd0);
    reset = 1'b0;
    tick();

    // Single read from poll requester, done 10 cycles after start.
    req = 4'b1000; addr_in = 32'h21_00_00_00;
    do_txn("single", 4'b1000, 8'h21, 1'b0, 8'h00, 10, 8'h45, 8'h45, lat);
    check("single_lat", 32'(lat), 32'd1);
    req = 4'b0000;
    tick();
    check("single_idle_grant", 32'(grant), 32'd0);
    check("single_idle_busy", 32'(busy), 32'd0);

    // Fixed priority; requester 2 is a write and must leave rdata_out alone.
    addr_in = 32'h31_32_33_34; wdata_in = 32'hA1_A2_A3_A4; wr_in = 4'b0100;
    req = 4'b1110;
    do_txn("prio1", 4'b0010, 8'h33, 1'b0, 8'h00, 3, 8'h11, 8'h11, lat);
    req = 4'b1100;
    do_txn("prio2", 4'b0100, 8'h32, 1'b1, 8'hA2, 4, 8'hEE, 8'h11, lat);
    req = 4'b1000;
    do_txn("prio3", 4'b1000, 8'h31, 1'b0, 8'h00, 2, 8'h22, 8'h22, lat);
    req = 4'b0000; wr_in = 4'b0000;
    tick();

    // Plan burst: requester 1 locked with requester 3 waiting.
    req = 4'b1010; lock = 4'b0010;
    for (int k = 0; k < 9; k++) begin
      do_txn($sformatf("burst1_%0d", k), 4'b0010, 8'h33, 1'b0, 8'h00, 2, 8'(k), 8'(k), lat);
    end
    req = 4'b1000;
    do_txn("burst1_after", 4'b1000, 8'h31, 1'b0, 8'h00, 2, 8'h30, 8'h30, lat);
    req = 4'b0000; lock = 4'b0000;
    tick();

    // Lock on low-priority 3 overrides priority of 1 for exactly 8 grants.
    req = 4'b1000; lock = 4'b1000;
    do_txn("burst3_0", 4'b1000, 8'h31, 1'b0, 8'h00, 2, 8'h40, 8'h40, lat);
    req = 4'b1010;
    for (int k = 1; k < 8; k++) begin
      do_txn($sformatf("burst3_%0d", k), 4'b1000, 8'h31, 1'b0, 8'h00, 2, 8'h40 + 8'(k), 8'h40 + 8'(k), lat);
    end
    do_txn("burst3_release", 4'b0010, 8'h33, 1'b0, 8'h00, 2, 8'h50, 8'h50, lat);
    req = 4'b0000; lock = 4'b0000;
    tick();

    // Watchdog on a locked owner: take the lock first, then never complete.
    req = 4'b1000; lock = 4'b1000;
    do_txn("wd_pre", 4'b1000, 8'h31, 1'b0, 8'h00, 2, 8'h77, 8'h77, lat);
    m = 0;
    tick();
    while (!txn_start && m < 8) begin tick(); m++; end
    check("wd_start", 32'(txn_start), 32'd1);
    m = 0;
    while (ack == 4'b0000 && m < 40) begin tick(); m++; end
    check("wd_latency", 32'(m), 32'd16);
    check("wd_ack", 32'(ack), 32'b1000);
    check("wd_err", 32'(err), 32'd1);
    check("wd_rdata", 32'(rdata_out), 32'h77);
    $display("txn wd: ack=%b err=%b after %0d cycles", ack, err, m);
    req = 4'b1010;
    do_txn("wd_unlocked", 4'b0010, 8'h33, 1'b0, 8'h00, 2, 8'h66, 8'h66, lat);
    req = 4'b0000; lock = 4'b0000;
    tick();
    check("wd_err_clear", 32'(err), 32'd0);

    // Completion on the watchdog limit cycle wins over timeout.
    req = 4'b1000;
    do_txn("limit", 4'b1000, 8'h31, 1'b0, 8'h00, 15, 8'h5A, 8'h5A, lat);
    req = 4'b0000;
    tick();

    // Reset in WAIT aborts silently; pending init request issues afterwards.
    req = 4'b1000;
    tick(); tick(); tick();
    check("rstw_busy_before", 32'(busy), 32'd1);
    reset = 1'b1; req = 4'b0001;
    tick();
    reset = 1'b0;
    check("rstw_grant", 32'(grant), 32'd0);
    check("rstw_ack", 32'(ack), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_err", 32'(err), 32'd0);
    check("rstw_rdata", 32'(rdata_out), 32'd0);
    do_txn("rstw_init", 4'b0001, 8'h34, 1'b0, 8'h00, 3, 8'h99, 8'h99, lat);
    check("rstw_lat", 32'(lat), 32'd1);
    req = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
